// File: rtl/fix_field_assembler.sv
// Assembles fix_parser tag/value strobes into binary-tag records held in a 2-entry output buffer.
// Define FIX_FIELD_STATS_EN to add record, drop and protocol-error counters.
module fix_field_assembler #(
  parameter int TAG_W       = 16,
  parameter int MAX_VAL_LEN = 32,
  parameter int LEN_W       = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               data_i,
  input  logic                     tag_s_i,
  input  logic                     tag_e_i,
  input  logic                     value_s_i,
  input  logic                     value_e_i,
  output logic                     fld_valid_o,
  input  logic                     fld_ready_i,
  output logic [TAG_W-1:0]         fld_tag_o,
  output logic [LEN_W-1:0]         fld_len_o,
  output logic [8*MAX_VAL_LEN-1:0] fld_data_o,
  output logic                     fld_trunc_o,
  output logic                     fld_err_o,
  output logic                     drop_o,
  output logic                     proto_err_o,
  output logic [1:0]               dbg_state
`ifdef FIX_FIELD_STATS_EN
  ,
  output logic [31:0]              fld_cnt_o,
  output logic [15:0]              drop_cnt_o,
  output logic [15:0]              perr_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, TAG, WAIT_VAL, VALUE} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]         tag;
    logic [LEN_W-1:0]         len;
    logic [8*MAX_VAL_LEN-1:0] data;
    logic                     trunc;
    logic                     err;
  } rec_t;

  state_t                   state, state_nxt;
  logic [TAG_W-1:0]         tag_acc, tag_nxt, step_tag;
  logic                     err_acc, err_nxt, step_err;
  logic [LEN_W-1:0]         len_acc, len_nxt, base_len, val_len;
  logic [8*MAX_VAL_LEN-1:0] data_acc, data_nxt, val_data;
  logic                     trunc_acc, trunc_nxt, val_trunc;
  logic [TAG_W+3:0]         tag_wide, digit_w, tag_step;
  logic                     digit_ok, overflow;
  logic                     complete, perr;
  rec_t                     rec_in;

  // Tag and value update for the byte currently on data_i; a start strobe begins from zero.
  always_comb begin
    digit_ok = (data_i >= 8'h30) && (data_i <= 8'h39);
    tag_wide = '0;
    tag_wide[TAG_W-1:0] = tag_s_i ? '0 : tag_acc;
    digit_w = '0;
    digit_w[3:0] = data_i[3:0];
    tag_step = (tag_wide << 3) + (tag_wide << 1) + digit_w;
    overflow = digit_ok && (|tag_step[TAG_W+3:TAG_W]);
    if (!digit_ok)     step_tag = tag_wide[TAG_W-1:0];
    else if (overflow) step_tag = '1;
    else               step_tag = tag_step[TAG_W-1:0];
    step_err  = (!tag_s_i && err_acc) || !digit_ok || overflow;
    base_len  = value_s_i ? '0 : len_acc;
    val_data  = value_s_i ? '0 : data_acc;
    val_trunc = !value_s_i && trunc_acc;
    val_len   = base_len;
    if (base_len < LEN_W'(MAX_VAL_LEN)) begin
      val_data[{base_len, 3'b000} +: 8] = data_i;
      val_len = base_len + LEN_W'(1);
    end else begin
      val_trunc = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A tag start always wins: it abandons whatever field is open and restarts the tag.
  always_comb begin
    state_nxt = state;
    tag_nxt   = tag_acc;
    err_nxt   = err_acc;
    len_nxt   = len_acc;
    data_nxt  = data_acc;
    trunc_nxt = trunc_acc;
    complete  = 1'b0;
    perr      = 1'b0;
    if (tag_s_i) begin
      perr      = (state != IDLE);
      tag_nxt   = step_tag;
      err_nxt   = step_err;
      state_nxt = tag_e_i ? WAIT_VAL : TAG;
    end else begin
      case (state)
        IDLE: perr = value_s_i;
        TAG: begin
          if (value_s_i) begin
            perr      = 1'b1;
            state_nxt = IDLE;
          end else begin
            tag_nxt = step_tag;
            err_nxt = step_err;
            if (tag_e_i) state_nxt = WAIT_VAL;
          end
        end
        WAIT_VAL: begin
          if (value_s_i) begin
            len_nxt   = val_len;
            data_nxt  = val_data;
            trunc_nxt = val_trunc;
            complete  = value_e_i;
            state_nxt = value_e_i ? IDLE : VALUE;
          end
        end
        VALUE: begin
          if (value_s_i) begin
            perr      = 1'b1;
            state_nxt = IDLE;
          end else begin
            len_nxt   = val_len;
            data_nxt  = val_data;
            trunc_nxt = val_trunc;
            complete  = value_e_i;
            if (value_e_i) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_acc   <= '0;
      err_acc   <= 1'b0;
      len_acc   <= '0;
      data_acc  <= '0;
      trunc_acc <= 1'b0;
    end else begin
      tag_acc   <= tag_nxt;
      err_acc   <= err_nxt;
      len_acc   <= len_nxt;
      data_acc  <= data_nxt;
      trunc_acc <= trunc_nxt;
    end
  end

  always_comb begin
    rec_in.tag   = tag_acc;
    rec_in.len   = val_len;
    rec_in.data  = val_data;
    rec_in.trunc = val_trunc;
    rec_in.err   = err_acc;
  end

  // Handshake: a record transfers on any rising clk where fld_valid_o && fld_ready_i;
  // while valid && !ready the head record is held unchanged.
  rec_t       mem [2];
  logic       wr_ptr, rd_ptr, push, pop;
  logic [1:0] count;

  assign fld_valid_o = (count != 2'd0);
  assign pop         = fld_valid_o && fld_ready_i;
  assign push        = complete && ((count != 2'd2) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]      <= '0;
      mem[1]      <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      drop_o      <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rec_in;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      drop_o      <= complete && !push;
      proto_err_o <= perr;
    end
  end

  assign fld_tag_o   = mem[rd_ptr].tag;
  assign fld_len_o   = mem[rd_ptr].len;
  assign fld_data_o  = mem[rd_ptr].data;
  assign fld_trunc_o = mem[rd_ptr].trunc;
  assign fld_err_o   = mem[rd_ptr].err;
  assign dbg_state   = state;

`ifdef FIX_FIELD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fld_cnt_o  <= '0;
      drop_cnt_o <= '0;
      perr_cnt_o <= '0;
    end else begin
      if (push)        fld_cnt_o  <= fld_cnt_o + 32'd1;
      if (drop_o)      drop_cnt_o <= drop_cnt_o + 16'd1;
      if (proto_err_o) perr_cnt_o <= perr_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fix_field_assembler.sv
// Directed and randomized bench for fix_field_assembler with a queue-level reference model.
module tb_fix_field_assembler;

  localparam int REC_W = 16 + 6 + 256 + 1 + 1;

  logic         clk, rst;
  logic [7:0]   data_i;
  logic         tag_s_i, tag_e_i, value_s_i, value_e_i;
  logic         fld_valid_o, fld_ready_i;
  logic [15:0]  fld_tag_o;
  logic [5:0]   fld_len_o;
  logic [255:0] fld_data_o;
  logic         fld_trunc_o, fld_err_o, drop_o, proto_err_o;
  logic [1:0]   dbg_state;
`ifdef FIX_FIELD_STATS_EN
  logic [31:0]  fld_cnt_o;
  logic [15:0]  drop_cnt_o, perr_cnt_o;
`endif

  fix_field_assembler dut (
    .clk(clk), .rst(rst), .data_i(data_i),
    .tag_s_i(tag_s_i), .tag_e_i(tag_e_i), .value_s_i(value_s_i), .value_e_i(value_e_i),
    .fld_valid_o(fld_valid_o), .fld_ready_i(fld_ready_i),
    .fld_tag_o(fld_tag_o), .fld_len_o(fld_len_o), .fld_data_o(fld_data_o),
    .fld_trunc_o(fld_trunc_o), .fld_err_o(fld_err_o),
    .drop_o(drop_o), .proto_err_o(proto_err_o), .dbg_state(dbg_state)
`ifdef FIX_FIELD_STATS_EN
    , .fld_cnt_o(fld_cnt_o), .drop_cnt_o(drop_cnt_o), .perr_cnt_o(perr_cnt_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, n_drop_seen = 0, n_perr_seen = 0;
  int rdy_mode;
  logic             open_fld;
  logic             pend_comp, pend_perr, exp_drop, exp_perr;
  logic [REC_W-1:0] pend_rec;
  logic [REC_W-1:0] exp_q[$];
  logic [7:0]       tag_buf[$], val_buf[$];

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h required=%0h", name, obs, exp);
    end
  endtask

  // reference model: a record straight from the field text
  function automatic logic [REC_W-1:0] model_rec();
    int unsigned t = 0;
    logic        e = 1'b0;
    logic [255:0] d = '0;
    int n;
    foreach (tag_buf[i]) begin
      if (tag_buf[i] < 8'h30 || tag_buf[i] > 8'h39) e = 1'b1;
      else begin
        t = t * 10 + int'(tag_buf[i] - 8'h30);
        if (t > 65535) begin
          t = 65535;
          e = 1'b1;
        end
      end
    end
    n = val_buf.size();
    for (int i = 0; i < n && i < 32; i++) d[8*i +: 8] = val_buf[i];
    return {t[15:0], 6'((n > 32) ? 32 : n), d, n > 32, e};
  endfunction

  // driver tasks
  task automatic drive_byte(input logic [7:0] b, input logic ts, input logic te, input logic vs,
                            input logic ve, input logic perr, input logic comp,
                            input logic [REC_W-1:0] rec);
    @(posedge clk);
    #1;
    data_i = b; tag_s_i = ts; tag_e_i = te; value_s_i = vs; value_e_i = ve;
    fld_ready_i = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    pend_perr = perr; pend_comp = comp; pend_rec = rec;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_byte(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic soh();
    drive_byte(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic set_tag(input string s);
    tag_buf.delete();
    for (int i = 0; i < s.len(); i++) tag_buf.push_back(s[i]);
  endtask

  task automatic set_val(input string s);
    val_buf.delete();
    for (int i = 0; i < s.len(); i++) val_buf.push_back(s[i]);
  endtask

  // cut > 0 stops after that many value bytes, leaving the field open
  task automatic send_field(input int cut);
    logic [REC_W-1:0] r;
    logic last;
    int nv;
    r = model_rec();
    for (int i = 0; i < tag_buf.size(); i++) begin
      drive_byte(tag_buf[i], i == 0, i == tag_buf.size() - 1, 1'b0, 1'b0,
                 (i == 0) && open_fld, 1'b0, '0);
      open_fld = 1'b1;
    end
    drive_byte(8'h3D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    nv = (cut > 0) ? cut : val_buf.size();
    for (int i = 0; i < nv; i++) begin
      last = (cut == 0) && (i == nv - 1);
      drive_byte(val_buf[i], 1'b0, 1'b0, i == 0, last, 1'b0, last, r);
    end
    if (cut == 0) open_fld = 1'b0;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    data_i = '0; tag_s_i = 0; tag_e_i = 0; value_s_i = 0; value_e_i = 0;
    pend_comp = 1'b0; pend_perr = 1'b0; open_fld = 1'b0;
    #1;
    check("async_rst_valid", fld_valid_o, 1'b0);
    check("async_rst_data", fld_data_o, '0);
    idle(2);
    rst = 1'b0;
  endtask

  // scoreboard: buffer occupancy, drop and protocol-error expectations per cycle
  always @(negedge clk) begin
    logic [REC_W-1:0] hd;
    if (rst) begin
      exp_q.delete();
      exp_drop = 1'b0;
      exp_perr = 1'b0;
    end else begin
      check("valid", fld_valid_o, exp_q.size() != 0);
      check("drop", drop_o, exp_drop);
      check("proto_err", proto_err_o, exp_perr);
      if (exp_q.size() != 0) begin
        hd = exp_q[0];
        if (!hd[0]) check("head_tag", fld_tag_o, hd[279:264]);
        check("head_len", fld_len_o, hd[263:258]);
        check("head_data", fld_data_o, hd[257:2]);
        check("head_trunc", fld_trunc_o, hd[1]);
        check("head_err", fld_err_o, hd[0]);
      end
      if (drop_o) n_drop_seen++;
      if (proto_err_o) n_perr_seen++;
      if (exp_q.size() != 0 && fld_ready_i) void'(exp_q.pop_front());
      exp_drop = 1'b0;
      if (pend_comp) begin
        if (exp_q.size() < 2) exp_q.push_back(pend_rec);
        else exp_drop = 1'b1;
      end
      exp_perr = pend_perr;
    end
  end

  initial begin
    int base, v, n, cut;
    string s;
    logic [REC_W-1:0] r;
    rst = 1'b1; rdy_mode = 1; open_fld = 1'b0;
    data_i = '0; tag_s_i = 0; tag_e_i = 0; value_s_i = 0; value_e_i = 0; fld_ready_i = 1'b1;
    pend_comp = 1'b0; pend_perr = 1'b0; pend_rec = '0; exp_drop = 1'b0; exp_perr = 1'b0;
    idle(3);
    rst = 1'b0;
    check("rst_valid", fld_valid_o, 1'b0);
    check("rst_tag", fld_tag_o, 16'd0);
    check("rst_len", fld_len_o, 6'd0);
    check("rst_data", fld_data_o, '0);
    check("rst_trunc", fld_trunc_o, 1'b0);
    check("rst_err", fld_err_o, 1'b0);
    check("rst_drop", drop_o, 1'b0);
    check("rst_perr", proto_err_o, 1'b0);

    // basic field 35=8
    set_tag("35"); set_val("8"); send_field(0); soh();
    check("basic_valid", fld_valid_o, 1'b1);
    check("basic_tag", fld_tag_o, 16'd35);
    check("basic_len", fld_len_o, 6'd1);
    check("basic_data", fld_data_o, 256'h38);
    check("basic_flags", {fld_trunc_o, fld_err_o}, 2'b00);

    // long value
    set_tag("52"); set_val("20071123-05:30:00.000"); send_field(0); soh();
    check("long_tag", fld_tag_o, 16'd52);
    check("long_len", fld_len_o, 6'd21);
    check("long_byte0", fld_data_o[7:0], 8'h32);
    check("long_byte20", fld_data_o[167:160], 8'h30);
    check("long_trunc", fld_trunc_o, 1'b0);
    idle(2);

    // backpressure: 8 and 9 held, 35 dropped
    rdy_mode = 0;
    base = n_drop_seen;
    set_tag("8"); set_val("A"); send_field(0); soh();
    set_tag("9"); set_val("B"); send_field(0); soh();
    set_tag("35"); set_val("C"); send_field(0); soh();
    check("bp_head_tag", fld_tag_o, 16'd8);
    idle(3);
    check("bp_head_stable", fld_tag_o, 16'd8);
    check("bp_drop_count", n_drop_seen - base, 1);
    rdy_mode = 1;
    idle(4);
    check("bp_drained", fld_valid_o, 1'b0);

    // truncation, non-digit tag, tag overflow
    set_tag("58");
    val_buf.delete();
    for (int i = 0; i < 40; i++) val_buf.push_back(8'($urandom_range(33, 126)));
    r = model_rec();
    send_field(0); soh();
    check("trunc_len", fld_len_o, 6'd32);
    check("trunc_flag", fld_trunc_o, 1'b1);
    check("trunc_data", fld_data_o, r[257:2]);
    set_tag("3A"); set_val("z"); send_field(0); soh();
    check("nondigit_err", fld_err_o, 1'b1);
    set_tag("99999"); set_val("q"); send_field(0); soh();
    check("ovf_err", fld_err_o, 1'b1);
    check("ovf_tag", fld_tag_o, 16'hFFFF);
    idle(2);

    // protocol violations
    base = n_perr_seen;
    set_tag("11"); set_val("abcd"); send_field(2);
    set_tag("55"); set_val("xy"); send_field(0); soh();
    check("perr_new_tag", fld_tag_o, 16'd55);
    check("perr_new_len", fld_len_o, 6'd2);
    drive_byte(8'h7A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    idle(3);
    check("perr_count", n_perr_seen - base, 2);
    check("perr_no_record", fld_valid_o, 1'b0);

    // reset mid-value with one record buffered
    rdy_mode = 0;
    set_tag("8"); set_val("A"); send_field(0); soh();
    set_tag("10"); set_val("hello"); send_field(3);
    mid_reset();
`ifdef FIX_FIELD_STATS_EN
    check("stats_rst_fld", fld_cnt_o, 32'd0);
    check("stats_rst_drop", drop_cnt_o, 16'd0);
    check("stats_rst_perr", perr_cnt_o, 16'd0);
`endif
    rdy_mode = 1;
    set_tag("49"); set_val("PHLX"); send_field(0); soh();
    check("post_rst_tag", fld_tag_o, 16'd49);
    check("post_rst_len", fld_len_o, 6'd4);
`ifdef FIX_FIELD_STATS_EN
    check("stats_fld_cnt", fld_cnt_o, 32'd1);
`endif
    idle(2);

    // randomized fields with random ready
    rdy_mode = 2;
    for (int k = 0; k < 120; k++) begin
      v = (($urandom_range(0, 9) == 0) ? $urandom_range(60000, 999999) : $urandom_range(0, 9999));
      s = $sformatf("%0d", v);
      set_tag(s);
      if ($urandom_range(0, 9) == 0)
        tag_buf[$urandom_range(0, tag_buf.size() - 1)] = 8'($urandom_range(65, 90));
      n = $urandom_range(1, 40);
      val_buf.delete();
      for (int i = 0; i < n; i++) val_buf.push_back(8'($urandom_range(33, 126)));
      cut = (n >= 2 && $urandom_range(0, 9) == 0) ? $urandom_range(1, n - 1) : 0;
      send_field(cut);
      if (cut == 0) soh();
      idle($urandom_range(0, 2));
    end
    rdy_mode = 1;
    idle(5);
    check("final_drained", fld_valid_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fix_field_assembler.md
Name: fix_field_assembler

Overview:
- Sits directly downstream of fix_parser. Consumes its byte stream and its tag/value start/end strobes.
- Converts each ASCII decimal tag to binary and collects the value bytes into a record.
- Queues completed tag/value records in a 2-entry buffer with a valid/ready handshake toward the message-decode logic.
- The parser has no backpressure, so this block absorbs stalls and reports dropped fields.

Parameters:
- TAG_W, 16, width of the binary tag number.
- MAX_VAL_LEN, 32, maximum stored value bytes per field.
- LEN_W, 6, width of the length field; must hold MAX_VAL_LEN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- data_i  in  8  byte from fix_parser data_o
- tag_s_i  in  1  first tag byte on data_i
- tag_e_i  in  1  last tag byte on data_i; may coincide with tag_s_i
- value_s_i  in  1  first value byte on data_i
- value_e_i  in  1  last value byte on data_i; may coincide with value_s_i
- fld_valid_o  out  1  record available at buffer head
- fld_ready_i  in  1  consumer accepts head record
- fld_tag_o  out  TAG_W  binary tag
- fld_len_o  out  LEN_W  stored value byte count (1..MAX_VAL_LEN)
- fld_data_o  out  8*MAX_VAL_LEN  value byte k at [8k+:8]; unused bytes zero
- fld_trunc_o  out  1  value longer than MAX_VAL_LEN
- fld_err_o  out  1  tag contained a non-digit or overflowed TAG_W
- drop_o  out  1  one-cycle pulse: completed field discarded, buffer full
- proto_err_o  out  1  one-cycle pulse: strobe sequence violation

Behaviour:
- Reset: all outputs, the buffer and the FSM clear to 0/IDLE. fld_data_o is zero. A partial field in progress is discarded. There is no drop_o pulse on reset.
- Input sampling: inputs are sampled each rising clk. Bytes with no strobe active and no field open (the '=' and SOH delimiters) are ignored.
- FSM states: IDLE, TAG, WAIT_VAL, VALUE.
  - IDLE: tag_s_i goes to TAG, or to WAIT_VAL if tag_e_i is also high. value_s_i in IDLE pulses proto_err_o and is ignored.
  - TAG: each byte updates tag = tag*10 + (byte-0x30). A byte outside 0x30..0x39 sets the err flag. A result exceeding 2^TAG_W-1 sets the err flag, and the tag saturates to all-ones. tag_e_i goes to WAIT_VAL.
  - WAIT_VAL: value_s_i stores byte 0 and goes to VALUE. If value_e_i is also high, the field completes immediately.
  - VALUE: bytes are stored at index len while len < MAX_VAL_LEN. Excess bytes set trunc, and len holds at MAX_VAL_LEN. value_e_i completes the field and returns to IDLE.
- Strobe violations:
  - tag_s_i in TAG, WAIT_VAL or VALUE abandons the open field, pulses proto_err_o, and restarts with the new tag byte.
  - value_s_i in TAG or VALUE pulses proto_err_o, abandons the field and returns to IDLE.
- Completion: the record {tag, len, data, trunc, err} is pushed to the 2-entry FIFO in the cycle the end byte is sampled. fld_valid_o rises the next cycle, so latency is 1 cycle from the value_e_i byte.
- Handshake: the head pops when fld_valid_o && fld_ready_i. Head outputs stay stable while valid && !ready.
- Buffer full on completion:
  - If a pop occurs the same cycle, the push succeeds.
  - Otherwise the record is discarded and drop_o pulses the cycle after the end byte.
- FIFO pointers are 1-bit and wrap. Count is 0..2.

Optional Feature:
- Macro: FIX_FIELD_STATS_EN.
- When defined, three additional output ports exist:
  - fld_cnt_o[31:0]: records pushed.
  - drop_cnt_o[15:0]: drop_o pulses.
  - perr_cnt_o[15:0]: proto_err_o pulses.
- All three reset to 0. They increment in the cycle after the event, wrap silently, and never affect datapath behaviour.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Basic field: stream "35=8" with tag_s/tag_e on '3'/'5' and value_s+value_e on '8', fld_ready_i=1 -> one cycle after '8': fld_valid_o=1, fld_tag_o=35, fld_len_o=1, fld_data_o[7:0]=0x38, trunc=0, err=0.
- Long value: tag "52", value "20071123-05:30:00.000" -> fld_tag_o=52, fld_len_o=21, byte0=0x32, byte20=0x30, trunc=0.
- Backpressure: fld_ready_i=0, send fields 8, 9, 35 -> the first two are held with the head tag stable at 8. Field 35 produces a drop_o pulse. Raising ready yields tags 8 then 9, then fld_valid_o=0.
- Truncation and error: a 40-byte value -> fld_len_o=32, fld_trunc_o=1, and bytes 0..31 match the input. Tag "3A" -> fld_err_o=1.
- Protocol violations: tag_s_i arriving mid-value pulses proto_err_o and the new field emits correctly. value_s_i in IDLE pulses proto_err_o and produces no record.
- Reset mid-operation: assert rst during a value with 1 record buffered -> fld_valid_o=0 immediately (asynchronous), and the next "49=PHLX" completes cleanly with fld_tag_o=49, fld_len_o=4. With FIX_FIELD_STATS_EN defined, the counters read 0 after reset and fld_cnt_o=1 after this field.
